four_port_ram_arbiter: RTL and testbench
========================================

Name: four_port_ram_arbiter

Overview:
- Shares one 256x8 register array among four requesting cores. The array is initialised to identity content (Data[i] = i), read/write capable, single access per cycle.
- Round-robin arbitration with a req/ack handshake and a registered read-data return.
- Sits between the core ports and the shared lookup/scratch storage in the multiprocessor top level. Replaces unarbitrated combinational multi-port reads.

Parameters:
- ADDR_W, 8, address width; the array depth is 2^ADDR_W.
- DATA_W, 8, data width.
- INIT_IDENTITY, 1, if 1 the reset sweep writes Data[i] = i[DATA_W-1:0]; if 0 it writes zero.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-port request, bit k = core k; held high until ack[k].
- we  input  4  per-port write enable, sampled with req[k].
- addr0..addr3  input  ADDR_W each  per-port address.
- wdata0..wdata3  input  DATA_W each  per-port write data.
- ack  output  4  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  shared return data, valid while any ack bit is high.
- ready  output  1  high once the init sweep is complete.

Behaviour:
- Reset values: ack=0, rdata=0, ready=0, init counter=0, round-robin pointer=0, last-grant mask=0, state=INIT.
- Any cycle with reset=1 forces the reset values, including mid-sweep or mid-access. A pending ack is dropped; the requester must re-issue.
- State INIT:
  - Each cycle writes Data[cnt] = cnt (or 0), then increments cnt.
  - When cnt==2^ADDR_W-1 is written, go to RUN.
  - The 256 writes occur in the first 256 cycles after reset deasserts; ready=1 from cycle 256 onward.
  - req is ignored during INIT; it is not latched, so requests stay pending.
- State RUN (terminal until reset):
  - Eligible set = req & ~mask, where mask = ack (the port acked this cycle is excluded). This prevents a held req from being re-granted while the requester sees ack.
  - Grant = first eligible port searching ptr, ptr+1, ... mod 4.
  - On a grant g in cycle N:
    - if we[g], Data[addr_g] <= wdata_g;
    - next cycle: ack <= onehot(g), rdata <= (we[g] ? wdata_g : Data[addr_g] before the edge);
    - ptr <= g+1 mod 4.
  - No eligible request: ack <= 0, rdata holds its previous value, ptr unchanged.
- Latency: a request seen in cycle N (RUN, eligible) is acked in N+1.
- Throughput: one access per cycle across ports. A single port gets at most one access per 2 cycles; it may present a new request in the cycle after its ack.
- Requester contract: addr/we/wdata must stay stable while req is high and unacked. Changing them before ack is undefined.
- Simultaneous requests: strict round-robin, so no port waits more than 3 grants while continuously requesting.
- Address wrap: addresses are exactly ADDR_W bits, no out-of-range case. The counter wraps 255->0 only at the INIT exit, which is unobservable.
- No combinational path from req to ack or rdata; all outputs are registered.

Decomposition:
- Shared package holds:
  - NUM_PORTS=4;
  - state encoding ST_INIT/ST_RUN;
  - the round-robin pick function (4-bit eligible plus 2-bit ptr in, 2-bit grant plus valid out).
- One sub-module, shared_ram_array:
  - 2^ADDR_W x DATA_W registers;
  - one synchronous write port and one asynchronous read port;
  - no reset of its own, because content comes from the INIT sweep.
- The arbiter FSM, pointer and handshake stay in four_port_ram_arbiter.

Test Plan:
1. Init sweep: release reset, hold all req low. ready=0 for cycles 0-255 and =1 at cycle 256. Then a port2 read of addr 0x5A returns ack=4'b0100, rdata=0x5A one cycle later.
2. Request during INIT: raise req[1] (read, addr 0x03) at cycle 10 after reset. No ack through cycle 256; ack=4'b0010 with rdata=0x03 at cycle 257.
3. Full contention: all four ports assert read req in RUN with ptr=0 and hold until acked. Acks arrive 0001, 0010, 0100, 1000 on four consecutive cycles, rdata equals each port's address.
4. Write then read: port1 writes addr 0x10 data 0xC3 (ack returns rdata=0xC3). Port3 then reads 0x10 and gets 0xC3; a port0 read of 0x11 returns 0x11.
5. Fairness: ports 0 and 3 re-request immediately after every ack for 20 cycles. Grants alternate 0,3,0,3; each port receives 10 acks ±1; no back-to-back ack to the same port.
6. Reset mid-operation: write 0xFF to addr 0x20, then assert reset for 1 cycle while req[2] is pending. ack clears and ready drops. After the new sweep (256 cycles), a read of 0x20 returns 0x20.

Source files
------------

// File: rtl/four_port_ram_arbiter_pkg.sv
// Shared definitions for the four-port RAM arbiter: port count, FSM states
// and the round-robin pick helper.
package four_port_ram_arbiter_pkg;

    localparam int NUM_PORTS = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] grant;
    } rr_pick_t;

    // First eligible port searching ptr, ptr+1, ... (mod 4). Scanning from the
    // far end down lets the closest candidate overwrite earlier hits.
    function automatic rr_pick_t rr_pick(input logic [NUM_PORTS-1:0] eligible,
                                         input logic [1:0]           ptr);
        rr_pick_t   pick;
        logic [1:0] idx;
        pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (eligible[idx]) begin
                pick.valid = 1'b1;
                pick.grant = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/four_port_ram_arbiter_if.sv
// Core-side bus of the four-port RAM arbiter: per-port request/command
// signals in, shared completion and return data out.
interface four_port_ram_arbiter_if
    import four_port_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] we;
    logic [ADDR_W-1:0]    addr0;
    logic [ADDR_W-1:0]    addr1;
    logic [ADDR_W-1:0]    addr2;
    logic [ADDR_W-1:0]    addr3;
    logic [DATA_W-1:0]    wdata0;
    logic [DATA_W-1:0]    wdata1;
    logic [DATA_W-1:0]    wdata2;
    logic [DATA_W-1:0]    wdata3;
    logic [NUM_PORTS-1:0] ack;
    logic [DATA_W-1:0]    rdata;
    logic                 ready;

    modport master (
        output req, we, addr0, addr1, addr2, addr3,
        output wdata0, wdata1, wdata2, wdata3,
        input  ack, rdata, ready
    );

    modport slave (
        input  req, we, addr0, addr1, addr2, addr3,
        input  wdata0, wdata1, wdata2, wdata3,
        output ack, rdata, ready
    );
endinterface

// File: rtl/four_port_ram_arbiter_shared_ram_array.sv
// Shared storage: one synchronous write port, one asynchronous read port.
// No reset; contents are established by the arbiter's init sweep.
module shared_ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/four_port_ram_arbiter.sv
// Round-robin arbiter giving four cores one-access-per-cycle use of a shared
// RAM, with an init sweep after reset and registered ack/rdata return.
module four_port_ram_arbiter
    import four_port_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int INIT_IDENTITY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    four_port_ram_arbiter_if.slave   bus
);
    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    cnt_reg, cnt_next;
    logic [1:0]           ptr_reg, ptr_next;
    logic [NUM_PORTS-1:0] ack_reg, ack_next;
    logic [DATA_W-1:0]    rdata_reg, rdata_next;
    logic                 ready_reg, ready_next;

    logic [ADDR_W-1:0]    port_addr  [NUM_PORTS];
    logic [DATA_W-1:0]    port_wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_onehot;
    rr_pick_t             pick;

    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    assign port_addr[0]  = bus.addr0;
    assign port_addr[1]  = bus.addr1;
    assign port_addr[2]  = bus.addr2;
    assign port_addr[3]  = bus.addr3;
    assign port_wdata[0] = bus.wdata0;
    assign port_wdata[1] = bus.wdata1;
    assign port_wdata[2] = bus.wdata2;
    assign port_wdata[3] = bus.wdata3;

    // The port acked this cycle is masked so its still-high req is not re-granted.
    assign pick = rr_pick(bus.req & ~ack_reg, ptr_reg);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
            assign grant_onehot[gi] = pick.valid && (pick.grant == 2'(gi));
        end
    endgenerate

    shared_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (port_addr[pick.grant]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
            ready_reg <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        ack_next   = '0;
        rdata_next = rdata_reg;
        ready_next = ready_reg;
        mem_we     = 1'b0;
        mem_waddr  = cnt_reg;
        mem_wdata  = (INIT_IDENTITY != 0) ? DATA_W'(cnt_reg) : '0;

        case (state_reg)
            ST_INIT: begin
                mem_we   = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == {ADDR_W{1'b1}}) begin
                    state_next = ST_RUN;
                    ready_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (pick.valid) begin
                    ack_next = grant_onehot;
                    ptr_next = pick.grant + 2'd1;
                    if (bus.we[pick.grant]) begin
                        mem_we     = 1'b1;
                        mem_waddr  = port_addr[pick.grant];
                        mem_wdata  = port_wdata[pick.grant];
                        rdata_next = port_wdata[pick.grant];
                    end else begin
                        rdata_next = mem_rdata;
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign bus.ack   = ack_reg;
    assign bus.rdata = rdata_reg;
    assign bus.ready = ready_reg;
endmodule

// File: tb/tb_four_port_ram_arbiter.sv
// Self-checking bench for four_port_ram_arbiter: directed scenarios plus
// random traffic, all scored against a cycle-level reference model.
module tb_four_port_ram_arbiter;
    import four_port_ram_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] req_d, we_d;
    logic [7:0] addr_d  [4];
    logic [7:0] wdata_d [4];

    four_port_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    assign bus.req    = req_d;
    assign bus.we     = we_d;
    assign bus.addr0  = addr_d[0];
    assign bus.addr1  = addr_d[1];
    assign bus.addr2  = addr_d[2];
    assign bus.addr3  = addr_d[3];
    assign bus.wdata0 = wdata_d[0];
    assign bus.wdata1 = wdata_d[1];
    assign bus.wdata2 = wdata_d[2];
    assign bus.wdata3 = wdata_d[3];

    four_port_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .INIT_IDENTITY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: storage contents, cycles since reset, next port to
    // favour, and the outputs expected in the current cycle.
    logic [7:0] mm [256];
    int         cyc;
    int         favour;
    logic [3:0] exp_ack;
    logic [7:0] exp_rdata;
    logic       exp_ready;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // Check the current cycle's outputs, advance the model by one clock.
    task automatic step();
        logic [3:0] n_ack;
        logic [3:0] elig;
        logic [7:0] n_rdata;
        logic       n_ready;
        int         g;
        @(negedge clk);
        check_value("ack", 32'(bus.ack), 32'(exp_ack));
        check_value("rdata", 32'(bus.rdata), 32'(exp_rdata));
        check_value("ready", 32'(bus.ready), 32'(exp_ready));
        n_ack   = '0;
        n_rdata = exp_rdata;
        n_ready = exp_ready;
        g       = -1;
        if (reset) begin
            n_rdata = '0;
            n_ready = 1'b0;
            cyc     = 0;
            favour  = 0;
        end else if (cyc < 256) begin
            mm[cyc] = 8'(cyc);
            cyc++;
            if (cyc == 256) n_ready = 1'b1;
        end else begin
            elig = req_d & ~exp_ack;
            for (int i = 0; i < 4; i++) begin
                if (g < 0 && elig[(favour + i) % 4]) g = (favour + i) % 4;
            end
            if (g >= 0) begin
                n_ack[g] = 1'b1;
                n_rdata  = we_d[g] ? wdata_d[g] : mm[addr_d[g]];
                if (we_d[g]) mm[addr_d[g]] = wdata_d[g];
                favour = (g + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        exp_ack   = n_ack;
        exp_rdata = n_rdata;
        exp_ready = n_ready;
        if (g >= 0)
            $display("txn port %0d %s addr %02h data %02h", g, we_d[g] ? "wr" : "rd", addr_d[g], n_rdata);
    endtask

    task automatic wait_ack(input int k, input logic [7:0] expd, input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (bus.ack[k]) begin
                got = 1'b1;
                check_value({tag, "_ack"}, 32'(bus.ack), 32'(1 << k));
                check_value({tag, "_rdata"}, 32'(bus.rdata), 32'(expd));
            end
        end
        check_value({tag, "_acked"}, 32'(got), 32'd1);
    endtask

    task automatic issue(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] expd, input string tag);
        req_d[k]   = 1'b1;
        we_d[k]    = w;
        addr_d[k]  = a;
        wdata_d[k] = d;
        wait_ack(k, expd, tag, 20);
        req_d[k] = 1'b0;
    endtask

    initial begin
        logic [3:0] a, prev;
        int         c0, c3;
        bit [3:0]   pend;
        reset = 1'b1;
        req_d = '0;
        we_d  = '0;
        for (int k = 0; k < 4; k++) begin
            addr_d[k]  = '0;
            wdata_d[k] = '0;
        end
        exp_ack = '0; exp_rdata = '0; exp_ready = 1'b0; cyc = 0; favour = 0;
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // Init sweep with a request raised at cycle 10 that must wait.
        for (int c = 0; c < 256; c++) begin
            if (c == 10) begin
                req_d[1] = 1'b1; we_d[1] = 1'b0; addr_d[1] = 8'h03;
            end
            if (c == 255) check_value("ready_low_255", 32'(bus.ready), 32'd0);
            step();
        end
        check_value("ready_at_256", 32'(bus.ready), 32'd1);
        check_value("no_ack_at_256", 32'(bus.ack), 32'd0);
        step();
        check_value("init_req_ack", 32'(bus.ack), 32'b0010);
        check_value("init_req_rdata", 32'(bus.rdata), 32'h03);
        req_d[1] = 1'b0;
        issue(2, 1'b0, 8'h5A, 8'h00, 8'h5A, "p2_rd_5a");

        // Full contention starting from pointer 0.
        issue(3, 1'b0, 8'h33, 8'h00, 8'h33, "ptr_to_0");
        for (int k = 0; k < 4; k++) begin
            req_d[k] = 1'b1; we_d[k] = 1'b0; addr_d[k] = 8'($urandom_range(0, 255));
        end
        step();
        for (int i = 0; i < 4; i++) begin
            check_value("cont_ack", 32'(bus.ack), 32'(1 << i));
            check_value("cont_rdata", 32'(bus.rdata), 32'(addr_d[i]));
            req_d[i] = 1'b0;
            step();
        end

        // Write then read back from other ports.
        issue(1, 1'b1, 8'h10, 8'hC3, 8'hC3, "p1_wr_10");
        issue(3, 1'b0, 8'h10, 8'h00, 8'hC3, "p3_rd_10");
        issue(0, 1'b0, 8'h11, 8'h00, 8'h11, "p0_rd_11");

        // Fairness between two continuously requesting ports.
        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 8'h40;
        req_d[3] = 1'b1; we_d[3] = 1'b0; addr_d[3] = 8'h43;
        c0 = 0; c3 = 0; prev = '0;
        for (int n = 0; n < 20; n++) begin
            step();
            a = bus.ack;
            if (a[0]) c0++;
            if (a[3]) c3++;
            if (a != 0) check_value("fair_no_b2b", 32'(a == prev), 32'd0);
            prev = a;
        end
        req_d = '0;
        check_value("fair_cnt0", 32'(c0 >= 9 && c0 <= 11), 32'd1);
        check_value("fair_cnt3", 32'(c3 >= 9 && c3 <= 11), 32'd1);
        step();

        // Reset mid-operation with a pending request that must survive the sweep.
        issue(1, 1'b1, 8'h20, 8'hFF, 8'hFF, "wr_20_ff");
        req_d[2] = 1'b1; we_d[2] = 1'b0; addr_d[2] = 8'h20;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("rst_ack_clear", 32'(bus.ack), 32'd0);
        check_value("rst_ready_low", 32'(bus.ready), 32'd0);
        wait_ack(2, 8'h20, "rst_rd_20", 300);
        req_d[2] = 1'b0;

        // Random traffic against the model.
        pend = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (exp_ack[k]) pend[k] = 1'b0;
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]    = 1'b1;
                    we_d[k]    = 1'($urandom_range(0, 1));
                    addr_d[k]  = 8'($urandom_range(0, 31));
                    wdata_d[k] = 8'($urandom);
                end
                req_d[k] = pend[k];
            end
            step();
        end
        req_d = '0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
